bram_sequencer: RTL and testbench
=================================

BRAM_SEQUENCER -- requirements
Module: bram_sequencer

Interface
REQ-001 Parameter BUS_WIDTH, default 32: word width of the stream and coupler data.
REQ-002 Parameter ROWS, default 1: number of coupler rows; coupler data_out is ROWS*BUS_WIDTH wide.
REQ-003 Parameter ADDR_WIDTH, default 10: width of row_width and r_add.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a fill/drain pass; ignored unless IDLE.
REQ-007 row_width  in  ADDR_WIDTH  words per row; sampled on accepted start.
REQ-008 s_data / s_valid / s_ready  in / in / out  BUS_WIDTH / 1 / 1  input word stream with valid/ready handshake.
REQ-009 wr_en / data_in  out / out  1 / BUS_WIDTH  coupler write strobe and word.
REQ-010 r_en / r_add  out / out  1 / ADDR_WIDTH  coupler read strobe and column address.
REQ-011 cpl_data / cpl_valid / cpl_full  in / in / in  ROWS*BUS_WIDTH / 1 / 1  coupler read data, read-valid, full.
REQ-012 m_data / m_valid / m_ready  out / out / in  ROWS*BUS_WIDTH / 1 / 1  output column stream.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse on pass completion.
REQ-015 error  out  1  sticky timeout flag (see Configuration).

Function
REQ-016 States SHALL be IDLE, FILL, READ, WAIT_RD, HOLD.
REQ-017 IDLE: start=1 with row_width!=0 SHALL latch row_width, clear counters, go to FILL; start with row_width==0 SHALL pulse done the next cycle and stay IDLE.
REQ-018 FILL: s_ready=1 unless cpl_full=1; each s_valid&s_ready beat SHALL drive wr_en=1 and data_in=s_data combinationally in the same cycle and increment wcount.
REQ-019 FILL SHALL go to READ after the beat making wcount == row_width*ROWS, or on any cycle with cpl_full=1.
REQ-020 READ: SHALL assert r_en=1 for exactly one cycle with r_add=rcount, then go to WAIT_RD.
REQ-021 WAIT_RD: on cpl_valid=1, SHALL register cpl_data into m_data, set m_valid, go to HOLD.
REQ-022 HOLD: m_valid held with m_data stable until m_ready=1; on that transfer SHALL increment rcount and go to READ, or to IDLE with done=1 if rcount was row_width-1.
REQ-023 Throughput in drain SHALL be at most one column per 3 cycles; no read SHALL be issued while m_valid=1.
REQ-024 wr_en and r_en SHALL never be high in the same cycle.
REQ-025 cpl_valid outside WAIT_RD SHALL be ignored.
REQ-026 start while busy SHALL be ignored with no effect on the current pass.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE; s_ready, wr_en, r_en, m_valid, busy, done, error SHALL be 0; data_in, r_add, m_data, counters SHALL be 0.
REQ-028 Reset mid-pass SHALL abandon the pass with no done pulse; first start after release SHALL begin a fresh pass.

Configuration
REQ-029 Macro SEQ_TIMEOUT_EN: when defined, a 4-bit counter SHALL run in WAIT_RD; 15 cycles without cpl_valid SHALL set error=1 (sticky until reset) and return to IDLE without done.
REQ-030 Without SEQ_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely and error SHALL be tied to 0.

Verification
REQ-031 row_width=10, ROWS=1, stream 0..9 back-to-back, m_ready=1 -> 10 wr_en beats, reads r_add 0..9, m_data 0..9 in order, one done pulse, busy low after.
REQ-032 Same pass with m_ready toggled 1/0 every cycle -> m_data stable while stalled, no r_en while m_valid=1, output sequence 0..9 unchanged.
REQ-033 cpl_full forced high after 6 writes -> s_ready drops same cycle, FILL exits, drain covers r_add 0..9.
REQ-034 start with row_width=0 -> no wr_en/r_en, done pulses one cycle later; start pulsed during FILL -> ignored.
REQ-035 rst low during HOLD of column 4 -> all outputs 0 immediately, no done; new pass after release yields 0..9 correctly.
REQ-036 With SEQ_TIMEOUT_EN, cpl_valid suppressed after r_add=2 -> error=1 after 15 cycles, state IDLE, no done; without macro, bench sees busy held high.

Source files
------------

// File: rtl/bram_sequencer.sv
// Fill/drain sequencer: streams words into a BRAM coupler, then reads them back column by column.
// Optional feature macro: SEQ_TIMEOUT_EN (WAIT_RD watchdog with a sticky error flag).
module bram_sequencer #(
    parameter int BUS_WIDTH  = 32,
    parameter int ROWS       = 1,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     row_width,
    input  logic [BUS_WIDTH-1:0]      s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [BUS_WIDTH-1:0]      data_in,
    output logic                      r_en,
    output logic [ADDR_WIDTH-1:0]     r_add,
    input  logic [ROWS*BUS_WIDTH-1:0] cpl_data,
    input  logic                      cpl_valid,
    input  logic                      cpl_full,
    output logic [ROWS*BUS_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    // state   | meaning
    // IDLE    | waiting for start
    // FILL    | accepting stream words into the coupler
    // READ    | one-cycle read strobe for column rcount
    // WAIT_RD | waiting for coupler read data
    // HOLD    | column presented on m_data until m_ready

    localparam int CNT_W = ADDR_WIDTH + $clog2(ROWS) + 1;

    typedef enum logic [2:0] {IDLE, FILL, READ, WAIT_RD, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  row_w;
    logic [ADDR_WIDTH-1:0]  rcount;
    logic [CNT_W-1:0]       wcount;
    logic [CNT_W-1:0]       wtarget;
    logic                   last_col;
    logic                   timeout;

    assign wtarget  = CNT_W'(row_w) * CNT_W'(ROWS);
    assign last_col = (rcount == row_w - ADDR_WIDTH'(1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        wr_en     = 1'b0;
        data_in   = '0;
        r_en      = 1'b0;
        r_add     = '0;
        case (state)
            IDLE: begin
                if (start && row_width != '0) state_nxt = FILL;
            end
            FILL: begin
                s_ready = !cpl_full;
                wr_en   = s_valid && !cpl_full;
                if (wr_en) data_in = s_data;
                if (cpl_full || (wr_en && (wcount + CNT_W'(1)) == wtarget))
                    state_nxt = READ;
            end
            READ: begin
                r_en      = 1'b1;
                r_add     = rcount;
                state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                if (cpl_valid)    state_nxt = HOLD;
                else if (timeout) state_nxt = IDLE;
            end
            HOLD: begin
                if (m_ready) state_nxt = last_col ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_w   <= '0;
            wcount  <= '0;
            rcount  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (row_width != '0) begin
                            row_w  <= row_width;
                            wcount <= '0;
                            rcount <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_en) wcount <= wcount + CNT_W'(1);
                end
                WAIT_RD: begin
                    if (cpl_valid) begin
                        m_data  <= cpl_data;
                        m_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        rcount  <= rcount + ADDR_WIDTH'(1);
                        if (last_col) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Fifteenth silent WAIT_RD cycle is the one where to_cnt reads 14.
    logic [3:0] to_cnt;

    assign timeout = (to_cnt == 4'd14);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (state == WAIT_RD) to_cnt <= to_cnt + 4'd1;
            else                  to_cnt <= '0;
            if (state == WAIT_RD && !cpl_valid && timeout) error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_bram_sequencer.sv
// Randomized bench for bram_sequencer with a coupler model and a stream-order reference.
// Honours SEQ_TIMEOUT_EN the same way the design does.
module tb_bram_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  row_width;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        wr_en;
    logic [31:0] data_in;
    logic        r_en;
    logic [9:0]  r_add;
    logic [31:0] cpl_data;
    logic        cpl_valid;
    logic        cpl_full;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    bram_sequencer #(.BUS_WIDTH(32), .ROWS(1), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start), .row_width(row_width),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wr_en(wr_en), .data_in(data_in), .r_en(r_en), .r_add(r_add),
        .cpl_data(cpl_data), .cpl_valid(cpl_valid), .cpl_full(cpl_full),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .error(error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_wr_en"},   wr_en,   0);
        check({tag, "_data_in"}, data_in, 0);
        check({tag, "_r_en"},    r_en,    0);
        check({tag, "_r_add"},   r_add,   0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"},  m_data,  0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_error"},   error,   0);
    endtask

    task automatic idle_inputs();
        start = 0; s_valid = 0; s_data = 0; cpl_valid = 0; cpl_data = 0;
        cpl_full = 0; m_ready = 0;
    endtask

    // mode: 0 = back-to-back stream of 0,1,2.. with m_ready=1, 1 = same stream with m_ready toggling,
    // 2 = random valid/ready/data. full_after/cut_col/rst_col < 0 disable those scenarios.
    task automatic run_pass(input int rw, input int mode, input int full_after,
                            input int cut_col, input int rst_col, input bit start_in_fill);
        logic [31:0] sent[$];
        logic [31:0] held = 0;
        logic [31:0] expw;
        int  n_sent = 0, exp_col = 0, exp_rd = 0, phase = 1, cyc = 0, fill_cyc = 0;
        int  pend_cnt = 0, pend_addr = 0, wait_cyc = -1, wptr = 0;
        bit  last_mv = 0, last_mr = 0, fin = 0, done_due = 0, hold_now;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hF000_0000 | i;
        @(negedge clk);
        start = 1; row_width = 10'(rw);
        @(negedge clk);
        start = 0;
        while (!fin && cyc < 3000) begin
            cyc++;
            hold_now = last_mv && !last_mr;
            s_valid  = (phase == 1) && (mode != 2 || $urandom_range(0, 3) != 0);
            s_data   = (mode == 2) ? $urandom : 32'(n_sent);
            cpl_full = (full_after >= 0 && n_sent >= full_after);
            case (mode)
                0:       m_ready = 1;
                1:       m_ready = (cyc % 2) == 1;
                default: m_ready = $urandom_range(0, 1) == 1;
            endcase
            if (exp_col == rst_col) m_ready = 0;
            start     = start_in_fill && phase == 1 && fill_cyc == 2;
            row_width = start ? 10'd5 : 10'(rw);
            if (pend_cnt == 1) begin
                cpl_valid = 1; cpl_data = mem[pend_addr]; pend_cnt = 0;
            end else if (pend_cnt > 1) begin
                cpl_valid = 0; pend_cnt--;
            end else begin
                cpl_valid = (phase == 1 || hold_now) && $urandom_range(0, 4) == 0;
                cpl_data  = $urandom;
            end
            #1;
            check("wr_rd_excl", wr_en & r_en, 0);
            check("done", done, done_due);
            if (done_due) begin
                check("busy_after_done", busy, 0);
                fin = 1;
            end
            if (phase == 1) begin
                fill_cyc++;
                check("busy_fill", busy, 1);
                check("s_ready", s_ready, !cpl_full);
                check("wr_en", wr_en, s_valid && !cpl_full);
                if (s_valid && !cpl_full) begin
                    check("data_in", data_in, s_data);
                    sent.push_back(s_data);
                    mem[wptr] = data_in;
                    wptr++;
                    n_sent++;
                end
                if (n_sent == rw || cpl_full) phase = 2;
            end else begin
                check("wr_en_drain", wr_en, 0);
            end
            if (wait_cyc >= 0) wait_cyc++;
            if (r_en) begin
                check("r_add", r_add, exp_rd);
                check("rd_while_mvalid", m_valid, 0);
                if (cut_col >= 0 && exp_rd > cut_col) wait_cyc = 0;
                else begin
                    pend_cnt  = $urandom_range(1, 3);
                    pend_addr = int'(r_add);
                end
                exp_rd++;
            end
            if (hold_now) begin
                check("m_valid_hold", m_valid, 1);
                check("m_stable", m_data, held);
            end
            done_due = 0;
            if (m_valid) begin
                held = m_data;
                if (m_ready) begin
                    expw = (exp_col < sent.size()) ? sent[exp_col] : (32'hF000_0000 | exp_col);
                    check("m_data", m_data, expw);
                    exp_col++;
                    if (exp_col == rw) done_due = 1;
                end
            end
            if (wait_cyc == 15) begin
                check("err_before_timeout", error, 0);
                check("busy_before_timeout", busy, 1);
            end
`ifdef SEQ_TIMEOUT_EN
            if (wait_cyc == 16) begin
                check("timeout_error", error, 1);
                check("timeout_idle", busy, 0);
                fin = 1;
            end
`else
            if (wait_cyc == 40) begin
                check("no_timeout_busy", busy, 1);
                check("no_timeout_error", error, 0);
                fin = 1;
            end
`endif
            if (rst_col >= 0 && m_valid && exp_col == rst_col) begin
                rst = 0;
                #1;
                check_all_zero("rst_mid");
                fin = 1;
            end
            last_mv = m_valid;
            last_mr = m_ready;
            if (!fin) @(negedge clk);
        end
        if (!fin) check("pass_budget", 0, 1);
        idle_inputs();
    endtask

    task automatic zero_pass();
        @(negedge clk);
        start = 1; row_width = 0;
        #1;
        check("zw_wr_en", wr_en, 0);
        check("zw_done_early", done, 0);
        @(negedge clk);
        start = 0;
        #1;
        check("zw_done", done, 1);
        check("zw_busy", busy, 0);
        check("zw_r_en", r_en, 0);
        @(negedge clk);
        #1;
        check("zw_done_clear", done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
    endtask

    initial begin
        idle_inputs();
        row_width = 0;
        rst = 1;
        #2 rst = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1;

        run_pass(10, 0, -1, -1, -1, 0);
        run_pass(10, 1, -1, -1, -1, 0);
        run_pass(10, 2, 6, -1, -1, 0);
        zero_pass();
        run_pass(10, 2, -1, -1, -1, 1);
        for (int k = 0; k < 6; k++)
            run_pass($urandom_range(1, 16), 2, -1, -1, -1, 0);

        run_pass(10, 2, -1, -1, 4, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_no_done", done, 0);
            check("rst_idle", busy, 0);
        end
        run_pass(10, 0, -1, -1, -1, 0);

        run_pass(10, 0, -1, 2, -1, 0);
        do_reset();
        check("error_cleared", error, 0);
        check("idle_after_cut", busy, 0);
        run_pass(7, 2, -1, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
